// File: rtl/pad_input_debounce_if.sv
// Pad-conditioning bundle: raw pad levels in, debounced level and edge strobes out.
interface pad_input_debounce_if #(
  parameter int unsigned WIDTH = 5
);
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] o;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  modport master (output i, input o, rise, fall, changed);
  modport slave  (input i, output o, rise, fall, changed);
endinterface

// File: rtl/pad_input_debounce.sv
// Per-bit synchroniser plus stability-count debouncer with registered rise/fall strobes.
module pad_input_debounce #(
  parameter int unsigned WIDTH         = 5,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned CNT_W         = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter bit          RESET_LEVEL   = 1'b0
) (
  input logic                 C,
  input logic                 R,
  pad_input_debounce_if.slave pad
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "pad_input_debounce: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES == 0) begin : g_bad_stable_lo
    $fatal(1, "pad_input_debounce: STABLE_CYCLES must be >= 1");
  end
  if (longint'(STABLE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_stable_hi
    $fatal(1, "pad_input_debounce: STABLE_CYCLES must be < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {StStable, StSettling} state_e;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_cnt  [WIDTH];
  state_e           r_state[WIDTH];
  logic [WIDTH-1:0] r_o;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_accept;

  assign w_s = r_sync[SYNC_STAGES-1];

  // A bit is accepted on the edge that sees its STABLE_CYCLES-th consecutive differing sample.
  always_comb begin
    w_accept = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      w_accept[b] = (w_s[b] != r_o[b]) && (r_cnt[b] == CntMax);
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= {WIDTH{RESET_LEVEL}};
      end
      for (int unsigned b = 0; b < WIDTH; b++) begin
        r_cnt[b]   <= '0;
        r_state[b] <= StStable;
      end
      r_o       <= {WIDTH{RESET_LEVEL}};
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_sync[0] <= pad.i;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end

      for (int unsigned b = 0; b < WIDTH; b++) begin
        unique case (r_state[b])
          StStable, StSettling: begin
            if (w_s[b] == r_o[b]) begin
              r_cnt[b]   <= '0;
              r_state[b] <= StStable;
            end else if (w_accept[b]) begin
              r_o[b]     <= w_s[b];
              r_cnt[b]   <= '0;
              r_state[b] <= StStable;
            end else begin
              r_cnt[b]   <= r_cnt[b] + CNT_W'(1);
              r_state[b] <= StSettling;
            end
          end
          default: begin
            r_cnt[b]   <= '0;
            r_state[b] <= StStable;
          end
        endcase
      end

      r_rise    <= w_accept & w_s;
      r_fall    <= w_accept & ~w_s;
      r_changed <= |w_accept;
    end
  end

  assign pad.o       = r_o;
  assign pad.rise    = r_rise;
  assign pad.fall    = r_fall;
  assign pad.changed = r_changed;

endmodule
